// File: rtl/seg_pkg.sv
// Shared constants and types for the scrolling message controller.
package seg_pkg;

    localparam logic [7:0] CHAR_BLANK = 8'h20;
    localparam int unsigned MSG_DEPTH = 16;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    // Clock cycles per scroll step; callers must keep the result >= 2.
    function automatic int unsigned step_cnt(input int unsigned clk_freq,
                                             input int unsigned step_ms);
        return clk_freq / 1000 * step_ms;
    endfunction

endpackage

// File: rtl/seg_step_timer.sv
// Enable-gated modulo-STEP_CNT counter; tick marks the last cycle of each step.
module seg_step_timer #(
    parameter int unsigned STEP_CNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = $clog2(STEP_CNT);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == CW'(STEP_CNT - 1));

    // Held clear while disabled, so every enable rise starts a full step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Message buffer plus right-to-left scroll scheduler feeding the 4-digit display driver.
module seg_scroll_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned STEP_MS  = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_dot,
    input  logic [4:0]  len,
    input  logic        start,
    input  logic        loop,
    input  logic        stop,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output logic [3:0]  dot_out
);

    localparam int unsigned STEP_CNT = step_cnt(CLK_FREQ, STEP_MS);

    state_e      state_q, state_d;
    logic [4:0]  step_q, step_d;
    logic [4:0]  len_q, len_d;
    logic        loop_q, loop_d;
    logic        done_q, done_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  dot_q, dot_d;
    logic [8:0]  mem_q [MSG_DEPTH];
    logic [4:0]  len_clamp;
    logic signed [5:0] idx;
    logic        tick;

    seg_step_timer #(
        .STEP_CNT (STEP_CNT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == StRun),
        .tick  (tick)
    );

    assign len_clamp = (len > 5'(MSG_DEPTH)) ? 5'(MSG_DEPTH) : len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                mem_q[i] <= {1'b0, CHAR_BLANK};
            end
        end else if (wr_en && state_q == StIdle) begin
            mem_q[wr_addr] <= {wr_dot, wr_data};
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        len_d   = len_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && len != 5'd0) begin
                    state_d = StRun;
                    step_d  = 5'd0;
                    len_d   = len_clamp;
                    loop_d  = loop;
                end
            end
            StRun: begin
                // stop takes priority over a tick landing in the same cycle
                if (stop) begin
                    state_d = StIdle;
                end else if (tick) begin
                    if (step_q == len_q + 5'd3) begin
                        done_d = 1'b1;
                        if (loop_q) begin
                            step_d = 5'd0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        step_d = step_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are built from next state so they line up with busy and the step change.
    always_comb begin
        data_d = {4{CHAR_BLANK}};
        dot_d  = 4'b0000;
        idx    = 6'sd0;
        if (state_d == StRun) begin
            for (int k = 0; k < 4; k++) begin
                idx = $signed({1'b0, step_d}) - $signed(6'(k));
                if (idx >= 6'sd0 && idx < $signed({1'b0, len_d})) begin
                    data_d[k*8 +: 8] = mem_q[idx[3:0]][7:0];
                    dot_d[k]         = mem_q[idx[3:0]][8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= 5'd0;
            len_q   <= 5'd0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= {4{CHAR_BLANK}};
            dot_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
            data_q  <= data_d;
            dot_q   <= dot_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = done_q;
    assign data_out = data_q;
    assign dot_out  = dot_q;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Directed bench for seg_scroll_ctrl with STEP_CNT = 4.
module tb_seg_scroll_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_dot = 1'b0;
    logic [4:0]  len = '0;
    logic        start = 1'b0;
    logic        loop = 1'b0;
    logic        stop = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic [3:0]  dot_out;

    int errors = 0;
    int checks = 0;

    seg_scroll_ctrl #(
        .CLK_FREQ (4000),
        .STEP_MS  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_dot   (wr_dot),
        .len      (len),
        .start    (start),
        .loop     (loop),
        .stop     (stop),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .dot_out  (dot_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic dt);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dot = dt;
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [4:0] l, input logic lp);
        start = 1'b1; len = l; loop = lp;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic step_chk(input string tag, input logic [31:0] d, input logic [3:0] dt);
        check({tag, ".data"}, data_out, d);
        check({tag, ".dot"}, {28'd0, dot_out}, {28'd0, dt});
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        check({tag, ".done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic end_chk(input string tag, input logic exp_busy);
        check({tag, ".done"}, {31'd0, done}, 32'd1);
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
    endtask

    task automatic quiet_watch(input string tag, input int n);
        logic bad;
        bad = 1'b0;
        repeat (n) begin
            cyc(1);
            if (done !== 1'b0 || busy !== 1'b0 || data_out !== 32'h20202020) bad = 1'b1;
        end
        check(tag, {31'd0, bad}, 32'd0);
    endtask

    initial begin
        #22 rst_n = 1'b1;
        cyc(1);

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            check("rst.data", data_out, 32'h20202020);
            check("rst.dot", {28'd0, dot_out}, 32'd0);
            check("rst.busy", {31'd0, busy}, 32'd0);
            cyc(1);
        end

        // "HI" with dot on 'I', len 2, single pass
        wr(4'd0, 8'h48, 1'b0);
        wr(4'd1, 8'h49, 1'b1);
        go(5'd2, 1'b0);
        step_chk("hi.s0", 32'h20202048, 4'b0000); cyc(4);
        step_chk("hi.s1", 32'h20204849, 4'b0001); cyc(4);
        step_chk("hi.s2", 32'h20484920, 4'b0010); cyc(4);
        step_chk("hi.s3", 32'h48492020, 4'b0100); cyc(4);
        step_chk("hi.s4", 32'h49202020, 4'b1000); cyc(3);
        step_chk("hi.s4end", 32'h49202020, 4'b1000); cyc(1);
        step_chk("hi.s5", 32'h20202020, 4'b0000); cyc(3);
        step_chk("hi.s5end", 32'h20202020, 4'b0000); cyc(1);
        end_chk("hi.end", 1'b0);
        check("hi.end.data", data_out, 32'h20202020);
        cyc(1);
        check("hi.end.pulse", {31'd0, done}, 32'd0);

        // len 0 must not start
        go(5'd0, 1'b0);
        check("len0.busy", {31'd0, busy}, 32'd0);
        quiet_watch("len0.quiet", 30);

        // len 20 clamps to 16: 20 steps, entry 15 last
        for (int i = 0; i < 16; i++) wr(4'(i), 8'h41 + 8'(i), (i == 15));
        go(5'd20, 1'b0);
        step_chk("l20.s0", 32'h20202041, 4'b0000); cyc(12);
        step_chk("l20.s3", 32'h41424344, 4'b0000); cyc(48);
        step_chk("l20.s15", 32'h4D4E4F50, 4'b0001); cyc(4);
        step_chk("l20.s16", 32'h4E4F5020, 4'b0010); cyc(8);
        step_chk("l20.s18", 32'h50202020, 4'b1000); cyc(4);
        step_chk("l20.s19", 32'h20202020, 4'b0000); cyc(4);
        end_chk("l20.end", 1'b0);

        // Loop mode, len 1: 5 steps = 20 cycles per pass
        go(5'd1, 1'b1);
        step_chk("lp.s0", 32'h20202041, 4'b0000); cyc(20);
        end_chk("lp.p1", 1'b1);
        check("lp.p1.data", data_out, 32'h20202041);
        cyc(1);
        check("lp.p1.pulse", {31'd0, done}, 32'd0);
        cyc(19);
        end_chk("lp.p2", 1'b1);
        cyc(19);
        step_chk("lp.last", 32'h20202020, 4'b0000);
        stop = 1'b1;  // lands on the final-tick cycle of pass 3
        cyc(1);
        stop = 1'b0;
        check("stop.busy", {31'd0, busy}, 32'd0);
        check("stop.done", {31'd0, done}, 32'd0);
        check("stop.data", data_out, 32'h20202020);
        quiet_watch("stop.quiet", 30);

        // Write while busy is dropped
        go(5'd1, 1'b0);
        wr(4'd0, 8'h5A, 1'b1);
        cyc(3);
        step_chk("wrb.s1", 32'h20204120, 4'b0000);
        cyc(16);
        end_chk("wrb.end", 1'b0);
        cyc(1);
        go(5'd1, 1'b0);
        step_chk("wrb.again", 32'h20202041, 4'b0000);
        cyc(20);
        end_chk("wrb.again.end", 1'b0);

        // Asynchronous reset in the middle of step 2
        cyc(1);
        go(5'd2, 1'b0);
        cyc(9);
        step_chk("rstm.s2", 32'h20414220, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        check("rstm.busy", {31'd0, busy}, 32'd0);
        check("rstm.done", {31'd0, done}, 32'd0);
        check("rstm.data", data_out, 32'h20202020);
        check("rstm.dot", {28'd0, dot_out}, 32'd0);
        #1 rst_n = 1'b1;
        cyc(1);
        go(5'd2, 1'b0);
        step_chk("rstm.r0", 32'h20202020, 4'b0000); cyc(4);
        step_chk("rstm.r1", 32'h20202020, 4'b0000); cyc(20);
        end_chk("rstm.end", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
